// File: rtl/cdb_scheduler_pkg.sv
// Shared unit indices and one-hot CDB source codes for the CDB scheduler and the CDB output mux.
// Bit order of the SEL codes is {int,div,mult,ls}, i.e. bit index == unit index.
package cdb_scheduler_pkg;

    localparam logic [1:0] UNIT_LS   = 2'd0;
    localparam logic [1:0] UNIT_MULT = 2'd1;
    localparam logic [1:0] UNIT_DIV  = 2'd2;
    localparam logic [1:0] UNIT_INT  = 2'd3;

    localparam logic [3:0] SEL_LS   = 4'b0001;
    localparam logic [3:0] SEL_MULT = 4'b0010;
    localparam logic [3:0] SEL_DIV  = 4'b0100;
    localparam logic [3:0] SEL_INT  = 4'b1000;

    function automatic logic [3:0] sel_of(input logic [1:0] unit);
        case (unit)
            UNIT_LS:   return SEL_LS;
            UNIT_MULT: return SEL_MULT;
            UNIT_DIV:  return SEL_DIV;
            default:   return SEL_INT;
        endcase
    endfunction

endpackage

// File: rtl/cdb_rsv_table.sv
// CDB reservation table: shift register of busy slots plus owner codes; slot 0 is held
// directly as the registered one-hot writeback select.
module cdb_rsv_table
    import cdb_scheduler_pkg::*;
#(
    parameter int INT_LAT  = 1,
    parameter int LS_LAT   = 1,
    parameter int MULT_LAT = 3,
    parameter int DIV_LAT  = 6,
    parameter int SLOTS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [3:0] unit_set,
    output logic [3:0] slot_free,
    output logic [3:0] wb_sel
);

    logic [SLOTS-1:1]            rsv;
    logic [SLOTS-1:1][1:0]       owner;
    logic [SLOTS-1:0]            rsv_nxt;
    logic [SLOTS-1:0][1:0]       own_nxt;

    // A unit's landing slot after this edge's shift is rsv[LAT] as seen now.
    always_comb begin
        slot_free            = '0;
        slot_free[UNIT_LS]   = !rsv[LS_LAT];
        slot_free[UNIT_MULT] = !rsv[MULT_LAT];
        slot_free[UNIT_DIV]  = !rsv[DIV_LAT];
        slot_free[UNIT_INT]  = !rsv[INT_LAT];
    end

    always_comb begin
        rsv_nxt = '0;
        own_nxt = '0;
        for (int k = 1; k < SLOTS; k++) begin
            rsv_nxt[k-1] = rsv[k];
            own_nxt[k-1] = owner[k];
        end
        if (unit_set[UNIT_LS]) begin
            rsv_nxt[LS_LAT-1] = 1'b1;
            own_nxt[LS_LAT-1] = UNIT_LS;
        end
        if (unit_set[UNIT_MULT]) begin
            rsv_nxt[MULT_LAT-1] = 1'b1;
            own_nxt[MULT_LAT-1] = UNIT_MULT;
        end
        if (unit_set[UNIT_DIV]) begin
            rsv_nxt[DIV_LAT-1] = 1'b1;
            own_nxt[DIV_LAT-1] = UNIT_DIV;
        end
        if (unit_set[UNIT_INT]) begin
            rsv_nxt[INT_LAT-1] = 1'b1;
            own_nxt[INT_LAT-1] = UNIT_INT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsv    <= '0;
            owner  <= '0;
            wb_sel <= '0;
        end else if (flush) begin
            rsv    <= '0;
            owner  <= '0;
            wb_sel <= '0;
        end else begin
            rsv    <= rsv_nxt[SLOTS-1:1];
            owner  <= own_nxt[SLOTS-1:1];
            wb_sel <= rsv_nxt[0] ? sel_of(own_nxt[0]) : 4'b0000;
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// CDB issue scheduler for int/ls/mult/div units: priority grants, div occupancy, CDB slot booking.
// Optional statistics counters are built when CDB_SCHED_STATS_EN is defined.
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter int INT_LAT  = 1,
    parameter int LS_LAT   = 1,
    parameter int MULT_LAT = 3,
    parameter int DIV_LAT  = 6,
    parameter int SLOTS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_int,
    input  logic        req_ls,
    input  logic        req_ls_store,
    input  logic        req_mult,
    input  logic        req_div,
    output logic        grant_int,
    output logic        grant_ls,
    output logic        grant_mult,
    output logic        grant_div,
    output logic        div_busy,
    output logic [3:0]  wb_sel,
    output logic        wb_valid
`ifdef CDB_SCHED_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_conflict,
    output logic [15:0] stat_busy
`endif
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    logic [3:0]       slot_free;
    logic [3:0]       unit_set;
    logic [CNT_W-1:0] div_cnt;
    logic             int_first;
    logic             active;
    logic             load_req, store_req;
    logic             div_ok, mult_ok, int_ok, load_ok, tie, load_win;

    // The divider may take a new op in the cycle its count is about to reach 0.
    always_comb begin
        active    = reset && !flush;
        load_req  = req_ls && !req_ls_store;
        store_req = req_ls && req_ls_store;
        div_ok    = req_div && (div_cnt <= CNT_W'(1)) && slot_free[UNIT_DIV];
        mult_ok   = req_mult && slot_free[UNIT_MULT]
                    && !(div_ok && (MULT_LAT == DIV_LAT));
        int_ok    = req_int && slot_free[UNIT_INT]
                    && !(div_ok && (INT_LAT == DIV_LAT))
                    && !(mult_ok && (INT_LAT == MULT_LAT));
        load_ok   = load_req && slot_free[UNIT_LS]
                    && !(div_ok && (LS_LAT == DIV_LAT))
                    && !(mult_ok && (LS_LAT == MULT_LAT));
        tie       = int_ok && load_ok;
        load_win  = load_ok && !(tie && int_first);

        grant_div  = active && div_ok;
        grant_mult = active && mult_ok;
        grant_int  = active && int_ok && !(tie && !int_first);
        grant_ls   = active && (load_win || store_req);

        unit_set            = '0;
        unit_set[UNIT_DIV]  = grant_div;
        unit_set[UNIT_MULT] = grant_mult;
        unit_set[UNIT_INT]  = grant_int;
        unit_set[UNIT_LS]   = active && load_win;
    end

    cdb_rsv_table #(
        .INT_LAT  (INT_LAT),
        .LS_LAT   (LS_LAT),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .SLOTS    (SLOTS)
    ) u_rsv_table (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .unit_set  (unit_set),
        .slot_free (slot_free),
        .wb_sel    (wb_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_first <= 1'b1;
        end else if (active && tie) begin
            int_first <= !int_first;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (flush) begin
            div_cnt <= '0;
        end else if (grant_div) begin
            div_cnt <= CNT_W'(DIV_LAT);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign div_busy = (div_cnt != '0);
    assign wb_valid = |wb_sel;

`ifdef CDB_SCHED_STATS_EN
    logic denied;

    always_comb begin
        denied = (req_int && !grant_int) || (req_ls && !grant_ls)
                 || (req_mult && !grant_mult) || (req_div && !grant_div);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_conflict <= '0;
            stat_busy     <= '0;
        end else if (stat_clr) begin
            stat_conflict <= '0;
            stat_busy     <= '0;
        end else begin
            if (denied && (stat_conflict != 16'hFFFF)) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
            if (wb_valid && (stat_busy != 16'hFFFF)) begin
                stat_busy <= stat_busy + 16'd1;
            end
        end
    end
`endif

    a_wb_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(wb_sel));

endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler: a calendar model books expected CDB writebacks into a sorted
// scoreboard queue as requests are driven; entries are popped when their cycle comes up.
module tb_cdb_scheduler;
    import cdb_scheduler_pkg::*;

    localparam int INT_LAT  = 1;
    localparam int LS_LAT   = 1;
    localparam int MULT_LAT = 3;
    localparam int DIV_LAT  = 6;
    localparam int SLOTS    = 8;
    localparam int NCYC     = 1024;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic       req_int, req_ls, req_ls_store, req_mult, req_div;
    logic       grant_int, grant_ls, grant_mult, grant_div;
    logic       div_busy, wb_valid;
    logic [3:0] wb_sel;
`ifdef CDB_SCHED_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_conflict, stat_busy;
`endif

    cdb_scheduler #(
        .INT_LAT(INT_LAT), .LS_LAT(LS_LAT), .MULT_LAT(MULT_LAT),
        .DIV_LAT(DIV_LAT), .SLOTS(SLOTS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_int      (req_int),
        .req_ls       (req_ls),
        .req_ls_store (req_ls_store),
        .req_mult     (req_mult),
        .req_div      (req_div),
        .grant_int    (grant_int),
        .grant_ls     (grant_ls),
        .grant_mult   (grant_mult),
        .grant_div    (grant_div),
        .div_busy     (div_busy),
        .wb_sel       (wb_sel),
        .wb_valid     (wb_valid)
`ifdef CDB_SCHED_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_conflict (stat_conflict),
        .stat_busy     (stat_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [3:0] s;
    } ev_t;

    ev_t        sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         t       = 0;
    int         m_lastdiv = -1000;
    bit         m_int_first = 1'b1;
    logic [3:0] obs_wb [NCYC];
    logic [3:0] obs_g  [NCYC];
    logic       obs_busy [NCYC];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic bit taken(input int c);
        foreach (sb[i]) if (sb[i].c == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sb_push(input int c, input logic [3:0] s);
        int i = 0;
        while (i < sb.size() && sb[i].c < c) i++;
        sb.insert(i, '{c, s});
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, advance the model.
    task automatic drive_cycle(input bit rst_a, input bit fl, input bit ri, input bit rl,
                               input bit rs, input bit rm, input bit rd);
        logic [3:0] exp_wb, exp_g;
        bit gd, gm, gi, gl, gs, ci, cl, exp_busy;
        reset        = !rst_a;
        flush        = fl;
        req_int      = ri;
        req_ls       = rl;
        req_ls_store = rs;
        req_mult     = rm;
        req_div      = rd;
        #1;
        if (rst_a) begin
            sb.delete();
            m_lastdiv   = -1000;
            m_int_first = 1'b1;
        end
        exp_wb = 4'b0000;
        if (sb.size() > 0 && sb[0].c == t) begin
            exp_wb = sb[0].s;
            void'(sb.pop_front());
        end
        exp_busy = !rst_a && (t > m_lastdiv) && (t <= m_lastdiv + DIV_LAT);
        {gd, gm, gi, gl, gs, ci, cl} = '0;
        if (!rst_a && !fl) begin
            gd = rd && (t >= m_lastdiv + DIV_LAT) && !taken(t + DIV_LAT);
            if (gd) begin
                sb_push(t + DIV_LAT, SEL_DIV);
                m_lastdiv = t;
            end
            gm = rm && !taken(t + MULT_LAT);
            if (gm) sb_push(t + MULT_LAT, SEL_MULT);
            ci = ri && !taken(t + INT_LAT);
            cl = rl && !rs && !taken(t + LS_LAT);
            if (ci && cl) begin
                gi = m_int_first;
                gl = !m_int_first;
                m_int_first = !m_int_first;
            end else begin
                gi = ci;
                gl = cl;
            end
            if (gi) sb_push(t + INT_LAT, SEL_INT);
            if (gl) sb_push(t + LS_LAT, SEL_LS);
            gs = rl && rs;
        end
        exp_g = {gi, gd, gm, gl | gs};
        check_val("wb_sel", 32'(wb_sel), 32'(exp_wb));
        check_val("wb_valid", 32'(wb_valid), 32'(|exp_wb));
        check_val("div_busy", 32'(div_busy), 32'(exp_busy));
        check_val("grants", 32'({grant_int, grant_div, grant_mult, grant_ls}), 32'(exp_g));
        if (fl && !rst_a) begin
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].c > t) sb.delete(i);
            m_lastdiv = -1000;
        end
        if (t < NCYC) begin
            obs_wb[t]   = wb_sel;
            obs_g[t]    = {grant_int, grant_div, grant_mult, grant_ls};
            obs_busy[t] = div_busy;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int t0;
        bit r_rst, r_fl;
        reset = 1'b0; flush = 1'b0;
        req_int = 1'b0; req_ls = 1'b0; req_ls_store = 1'b0; req_mult = 1'b0; req_div = 1'b0;
`ifdef CDB_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        @(negedge clk);

        // Reset held with every request up, then release
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1, 1, 0, 1, 1);
        check_val("rst_grants", 32'(obs_g[2]), 32'd0);
        check_val("rst_wb", 32'(obs_wb[2]), 32'd0);
        t0 = t;
        drive_cycle(0, 0, 1, 1, 0, 1, 1);
        idle(7);
        check_val("rel_div_grant", 32'(obs_g[t0][2]), 32'd1);
        check_val("rel_div_wb", 32'(obs_wb[t0 + 6]), 32'(4'b0100));
        check_val("rel_div_wb_early", 32'(obs_wb[t0 + 5]), 32'd0);

        // Back-to-back mult
        t0 = t;
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 0, 0, 1, 0);
        idle(5);
        for (int i = 3; i <= 6; i++) check_val("mult_stream", 32'(obs_wb[t0 + i]), 32'(4'b0010));

        // int / load alternation from a fresh int_first
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        t0 = t;
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 1, 0, 0, 0);
        idle(3);
        check_val("alt_g0", 32'(obs_g[t0]), 32'(4'b1000));
        check_val("alt_g1", 32'(obs_g[t0 + 1]), 32'(4'b0001));
        check_val("alt_g2", 32'(obs_g[t0 + 2]), 32'(4'b1000));
        check_val("alt_g3", 32'(obs_g[t0 + 3]), 32'(4'b0001));
        check_val("alt_wb1", 32'(obs_wb[t0 + 1]), 32'(4'b1000));
        check_val("alt_wb2", 32'(obs_wb[t0 + 2]), 32'(4'b0001));

        // int blocked by an in-flight mult landing in the same slot
        t0 = t;
        drive_cycle(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        drive_cycle(0, 0, 1, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 0, 0, 0);
        idle(3);
        check_val("blk_int_deny", 32'(obs_g[t0 + 2][3]), 32'd0);
        check_val("blk_int_grant", 32'(obs_g[t0 + 3][3]), 32'd1);
        check_val("blk_wb_mult", 32'(obs_wb[t0 + 3]), 32'(4'b0010));
        check_val("blk_wb_int", 32'(obs_wb[t0 + 4]), 32'(4'b1000));

        // Divider occupancy with req_div held
        t0 = t;
        for (int i = 0; i < 7; i++) drive_cycle(0, 0, 0, 0, 0, 0, 1);
        idle(7);
        for (int i = 1; i <= 6; i++) check_val("div_busy_win", 32'(obs_busy[t0 + i]), 32'd1);
        check_val("div_regrant_early", 32'(obs_g[t0 + 5][2]), 32'd0);
        check_val("div_regrant", 32'(obs_g[t0 + 6][2]), 32'd1);
        check_val("div_wb1", 32'(obs_wb[t0 + 6]), 32'(4'b0100));
        check_val("div_wb2", 32'(obs_wb[t0 + 12]), 32'(4'b0100));

        // Store alongside int, then flush drops mult/div results
        t0 = t;
        drive_cycle(0, 0, 1, 1, 1, 1, 1);
        drive_cycle(0, 1, 1, 1, 1, 1, 1);
        idle(8);
        check_val("st_grants", 32'(obs_g[t0]), 32'(4'b1111));
        check_val("st_wb_int", 32'(obs_wb[t0 + 1]), 32'(4'b1000));
        check_val("fl_grants", 32'(obs_g[t0 + 1]), 32'd0);
        check_val("fl_busy", 32'(obs_busy[t0 + 2]), 32'd0);
        for (int i = 2; i <= 9; i++) check_val("fl_wb_quiet", 32'(obs_wb[t0 + i]), 32'd0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            drive_cycle(r_rst, r_fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
